toaster_ctrl: RTL and testbench



---
 rtl/toaster_ctrl.sv | 130 +++++++++++++
 tb/tb_toaster_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/toaster_ctrl.sv
// Toaster sequencer: IDLE -> WARMUP -> TOAST -> COOL_DOWN -> IDLE, each phase timed by a shared down-counter.
// All outputs are registered; heater/fan decode the next state so they switch on the same edge as ooState.
module toaster_ctrl #(
  parameter int WARMUP_CYCLES     = 4,
  parameter int TOAST_UNIT_CYCLES = 8,
  parameter int COOL_CYCLES       = 6,
  parameter int CNT_W             = 8
) (
  input  logic             iiClk,
  input  logic             iiRstN,
  input  logic [1:0]       iiCmd,
  input  logic [1:0]       iiLevel,
  output logic [1:0]       ooState,
  output logic             ooHeater,
  output logic             ooFan,
  output logic [CNT_W-1:0] ooRemain,
  output logic             ooDone
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_TOAST  = 2'b10,
    ST_COOL   = 2'b11
  } state_t;

  localparam logic [1:0] CMD_START  = 2'b01;
  localparam logic [1:0] CMD_ABORT  = 2'b10;
  localparam logic [1:0] CMD_EXTEND = 2'b11;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNIT      = CNT_W'(TOAST_UNIT_CYCLES);
  localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(TOAST_UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       level_q, level_d;
  logic             heater_q, heater_d;
  logic             fan_q, fan_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cnt_dec;
  logic [CNT_W-1:0] toast_load;
  logic [CNT_W:0]   ext_sum;
  logic [CNT_W-1:0] ext_val;

  assign cnt_dec    = cnt_q - ONE;
  assign toast_load = (CNT_W'(level_q) + ONE) * UNIT - ONE;
  // One extra bit catches the carry so EXTEND saturates instead of wrapping.
  assign ext_sum    = {1'b0, cnt_q} + {1'b0, UNIT} - (CNT_W+1)'(1);
  assign ext_val    = ext_sum[CNT_W] ? CNT_MAX : ext_sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    level_d = level_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (iiCmd == CMD_START) begin
          state_d = ST_WARMUP;
          cnt_d   = WARM_LOAD;
          level_d = iiLevel;
        end
      end
      ST_WARMUP: begin
        if (iiCmd == CMD_ABORT) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_TOAST;
          cnt_d   = toast_load;
        end
      end
      ST_TOAST: begin
        if (iiCmd == CMD_ABORT) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end else if (iiCmd == CMD_EXTEND) begin
          cnt_d = (cnt_q == '0) ? UNIT_LOAD : ext_val;
        end else if (cnt_q == '0) begin
          state_d = ST_COOL;
          cnt_d   = COOL_LOAD;
        end
      end
      ST_COOL: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    heater_d = (state_d == ST_WARMUP) || (state_d == ST_TOAST);
    fan_d    = (state_d == ST_COOL);
  end

  always_ff @(posedge iiClk) begin
    if (!iiRstN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      level_q  <= 2'b00;
      heater_q <= 1'b0;
      fan_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      heater_q <= heater_d;
      fan_q    <= fan_d;
      done_q   <= done_d;
    end
  end

  assign ooState  = state_q;
  assign ooHeater = heater_q;
  assign ooFan    = fan_q;
  assign ooRemain = cnt_q;
  assign ooDone   = done_q;

endmodule

// File: tb/tb_toaster_ctrl.sv
// Directed bench: each stimulus cycle queues the hand-derived outputs expected after that edge;
// an independent monitor pops and compares one entry per clock.
module tb_toaster_ctrl;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, ABORT = 2'b10, EXT = 2'b11;
  localparam logic [1:0] S_I = 2'b00, S_W = 2'b01, S_T = 2'b10, S_C = 2'b11;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [1:0] lvl = 2'b00;
  logic [1:0] o_state;
  logic       o_heater, o_fan, o_done;
  logic [7:0] o_remain;

  typedef struct {
    logic [1:0] st;
    logic       ht;
    logic       fn;
    logic [7:0] rem;
    logic       dn;
    int         id;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_push = 0;

  toaster_ctrl #(
    .WARMUP_CYCLES(4),
    .TOAST_UNIT_CYCLES(8),
    .COOL_CYCLES(6),
    .CNT_W(8)
  ) dut (
    .iiClk   (clk),
    .iiRstN  (rstn),
    .iiCmd   (cmd),
    .iiLevel (lvl),
    .ooState (o_state),
    .ooHeater(o_heater),
    .ooFan   (o_fan),
    .ooRemain(o_remain),
    .ooDone  (o_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic cyc(input logic [1:0] c, input logic [1:0] l, input logic r,
                     input logic [1:0] st, input int rem, input logic dn);
    exp_t e;
    @(negedge clk);
    cmd  = c;
    lvl  = l;
    rstn = r;
    @(posedge clk);
    e.st  = st;
    e.ht  = (st == S_W) || (st == S_T);
    e.fn  = (st == S_C);
    e.rem = 8'(rem);
    e.dn  = dn;
    e.id  = n_push;
    n_push++;
    q.push_back(e);
  endtask

  task automatic phase(input logic [1:0] l, input logic [1:0] st, input int first, input int n);
    for (int i = 0; i < n; i++) cyc(NOP, l, 1'b1, st, first - i, 1'b0);
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        m = q.pop_front();
        total++;
        if (o_state !== m.st || o_heater !== m.ht || o_fan !== m.fn ||
            o_remain !== m.rem || o_done !== m.dn) begin
          bad++;
          $display("FAIL chk%0d: got st=%b heat=%b fan=%b rem=%0d done=%b, want st=%b heat=%b fan=%b rem=%0d done=%b",
                   m.id, o_state, o_heater, o_fan, o_remain, o_done,
                   m.st, m.ht, m.fn, m.rem, m.dn);
        end
      end
    end
  end

  initial begin
    // Reset holds everything at zero even with START present.
    cyc(START, 2'd3, 1'b0, S_I, 0, 1'b0);
    cyc(START, 2'd3, 1'b0, S_I, 0, 1'b0);
    cyc(NOP,   2'd0, 1'b1, S_I, 0, 1'b0);
    cyc(ABORT, 2'd0, 1'b1, S_I, 0, 1'b0);
    cyc(EXT,   2'd0, 1'b1, S_I, 0, 1'b0);

    // Level 0 uninterrupted: 4 warm, 8 toast, 6 cool, done on cycle 19.
    cyc(START, 2'd0, 1'b1, S_W, 3, 1'b0);
    phase(2'd0, S_W, 2, 3);
    phase(2'd0, S_T, 7, 8);
    phase(2'd0, S_C, 5, 6);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b0);

    // Level 3, with iiLevel wiggling mid-run: toast still 32 cycles.
    cyc(START, 2'd3, 1'b1, S_W, 3, 1'b0);
    phase(2'd0, S_W, 2, 3);
    phase(2'd1, S_T, 31, 32);
    phase(2'd2, S_C, 5, 6);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b0);

    // Level 1, ABORT on third toast cycle; ABORT in cool-down ignored.
    cyc(START, 2'd1, 1'b1, S_W, 3, 1'b0);
    phase(2'd1, S_W, 2, 3);
    phase(2'd1, S_T, 15, 3);
    cyc(ABORT, 2'd1, 1'b1, S_C, 5, 1'b0);
    cyc(ABORT, 2'd1, 1'b1, S_C, 4, 1'b0);
    phase(2'd1, S_C, 3, 4);
    cyc(NOP, 2'd1, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd1, 1'b1, S_I, 0, 1'b0);

    // Level 0, EXTEND at remain=2 (-> 9), then EXTEND at remain=0 (-> 7).
    cyc(START, 2'd0, 1'b1, S_W, 3, 1'b0);
    phase(2'd0, S_W, 2, 3);
    phase(2'd0, S_T, 7, 6);
    cyc(EXT, 2'd0, 1'b1, S_T, 9, 1'b0);
    phase(2'd0, S_T, 8, 9);
    cyc(EXT, 2'd0, 1'b1, S_T, 7, 1'b0);
    phase(2'd0, S_T, 6, 7);
    phase(2'd0, S_C, 5, 6);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd0, 1'b1, S_I, 0, 1'b0);

    // START, ABORT, EXTEND, NOP back to back: IDLE, WARMUP, COOL_DOWN, IDLE.
    cyc(START, 2'd2, 1'b1, S_W, 3, 1'b0);
    cyc(ABORT, 2'd2, 1'b1, S_C, 5, 1'b0);
    cyc(EXT,   2'd2, 1'b1, S_C, 4, 1'b0);
    cyc(NOP,   2'd2, 1'b1, S_C, 3, 1'b0);
    phase(2'd2, S_C, 2, 3);
    cyc(NOP, 2'd2, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd2, 1'b1, S_I, 0, 1'b0);

    // Level 3 with repeated EXTEND: +7 per cycle until saturating at 255.
    cyc(START, 2'd3, 1'b1, S_W, 3, 1'b0);
    phase(2'd3, S_W, 2, 3);
    cyc(NOP, 2'd3, 1'b1, S_T, 31, 1'b0);
    for (int k = 1; k <= 34; k++)
      cyc(EXT, 2'd3, 1'b1, S_T, (31 + 7 * k > 255) ? 255 : 31 + 7 * k, 1'b0);
    cyc(ABORT, 2'd3, 1'b1, S_C, 5, 1'b0);
    phase(2'd3, S_C, 4, 5);
    cyc(NOP, 2'd3, 1'b1, S_I, 0, 1'b1);
    cyc(NOP, 2'd3, 1'b1, S_I, 0, 1'b0);

    // Reset mid-toast: outputs cleared, no done pulse afterwards.
    cyc(START, 2'd2, 1'b1, S_W, 3, 1'b0);
    phase(2'd2, S_W, 2, 3);
    phase(2'd2, S_T, 23, 3);
    cyc(START, 2'd2, 1'b0, S_I, 0, 1'b0);
    cyc(NOP,   2'd2, 1'b1, S_I, 0, 1'b0);
    cyc(NOP,   2'd2, 1'b1, S_I, 0, 1'b0);

    // START in the done cycle restarts immediately; level latched by reset is 0.
    cyc(START, 2'd0, 1'b1, S_W, 3, 1'b0);
    phase(2'd0, S_W, 2, 3);
    phase(2'd0, S_T, 7, 8);
    phase(2'd0, S_C, 5, 6);
    cyc(NOP,   2'd0, 1'b1, S_I, 0, 1'b1);
    cyc(START, 2'd1, 1'b1, S_W, 3, 1'b0);
    phase(2'd1, S_W, 2, 3);
    cyc(NOP, 2'd1, 1'b1, S_T, 15, 1'b0);
    cyc(NOP, 2'd1, 1'b0, S_I, 0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
